// File: rtl/axi4_lite_arbiter_2to1.sv
// axi4_lite_arbiter_2to1: round-robin arbiter sharing one AXI4-Lite slave port between two requesters,
// one transaction outstanding at a time, write preferred over read within the winner.
module axi4_lite_arbiter_2to1 (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s0_awaddr,
  input  logic [2:0]  s0_awprot,
  input  logic        s0_awvalid,
  output logic        s0_awready,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  input  logic        s0_wvalid,
  output logic        s0_wready,
  output logic [1:0]  s0_bresp,
  output logic        s0_bvalid,
  input  logic        s0_bready,
  input  logic [31:0] s0_araddr,
  input  logic [2:0]  s0_arprot,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  input  logic [31:0] s1_awaddr,
  input  logic [2:0]  s1_awprot,
  input  logic        s1_awvalid,
  output logic        s1_awready,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  input  logic        s1_wvalid,
  output logic        s1_wready,
  output logic [1:0]  s1_bresp,
  output logic        s1_bvalid,
  input  logic        s1_bready,
  input  logic [31:0] s1_araddr,
  input  logic [2:0]  s1_arprot,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        grant_valid,
  output logic        grant_id,
  output logic        grant_wr
);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t r_state, w_next;
  logic r_id, r_last, r_aw_done, r_w_done, r_ar_done;
  logic w_wr, w_rd, w_req0, w_req1, w_win, w_win_wr, w_grant, w_b_hs, w_r_hs;
  logic w_o_awvalid, w_o_wvalid, w_o_arvalid, w_aw_hs, w_w_hs, w_ar_hs;
  assign w_wr = r_state == WR;
  assign w_rd = r_state == RD;
  assign w_req0 = s0_awvalid | s0_wvalid | s0_arvalid;
  assign w_req1 = s1_awvalid | s1_wvalid | s1_arvalid;
  // Contention goes to whoever did not finish last; a lone requester always wins
  assign w_win = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_win_wr = w_win ? (s1_awvalid | s1_wvalid) : (s0_awvalid | s0_wvalid);
  assign w_grant = (r_state == IDLE) & (w_req0 | w_req1);
  assign w_o_awvalid = r_id ? s1_awvalid : s0_awvalid;
  assign w_o_wvalid = r_id ? s1_wvalid : s0_wvalid;
  assign w_o_arvalid = r_id ? s1_arvalid : s0_arvalid;
  assign m_awaddr = w_wr ? (r_id ? s1_awaddr : s0_awaddr) : '0;
  assign m_awprot = w_wr ? (r_id ? s1_awprot : s0_awprot) : '0;
  assign m_awvalid = w_wr & w_o_awvalid & ~r_aw_done;
  assign m_wdata = w_wr ? (r_id ? s1_wdata : s0_wdata) : '0;
  assign m_wstrb = w_wr ? (r_id ? s1_wstrb : s0_wstrb) : '0;
  assign m_wvalid = w_wr & w_o_wvalid & ~r_w_done;
  assign m_bready = w_wr & (r_id ? s1_bready : s0_bready);
  assign m_araddr = w_rd ? (r_id ? s1_araddr : s0_araddr) : '0;
  assign m_arprot = w_rd ? (r_id ? s1_arprot : s0_arprot) : '0;
  assign m_arvalid = w_rd & w_o_arvalid & ~r_ar_done;
  assign m_rready = w_rd & (r_id ? s1_rready : s0_rready);
  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs = m_wvalid & m_wready;
  assign w_ar_hs = m_arvalid & m_arready;
  assign w_b_hs = m_bvalid & m_bready;
  assign w_r_hs = m_rvalid & m_rready;
  assign s0_awready = w_wr & ~r_id & m_awready & ~r_aw_done;
  assign s1_awready = w_wr & r_id & m_awready & ~r_aw_done;
  assign s0_wready = w_wr & ~r_id & m_wready & ~r_w_done;
  assign s1_wready = w_wr & r_id & m_wready & ~r_w_done;
  assign s0_arready = w_rd & ~r_id & m_arready & ~r_ar_done;
  assign s1_arready = w_rd & r_id & m_arready & ~r_ar_done;
  assign s0_bvalid = w_wr & ~r_id & m_bvalid;
  assign s1_bvalid = w_wr & r_id & m_bvalid;
  assign s0_rvalid = w_rd & ~r_id & m_rvalid;
  assign s1_rvalid = w_rd & r_id & m_rvalid;
  assign s0_bresp = m_bresp;
  assign s1_bresp = m_bresp;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign grant_valid = r_state != IDLE;
  assign grant_id = r_id;
  assign grant_wr = w_wr;
  always_comb begin
    w_next = r_state;
    if (w_grant) w_next = w_win_wr ? WR : RD;
    else if (w_b_hs | w_r_hs) w_next = IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_id <= 1'b0;
      r_last <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done <= 1'b0;
      r_ar_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) r_id <= w_win;
      if (w_b_hs | w_r_hs) r_last <= r_id;
      r_aw_done <= w_wr & ~w_b_hs & (r_aw_done | w_aw_hs);
      r_w_done <= w_wr & ~w_b_hs & (r_w_done | w_w_hs);
      r_ar_done <= w_rd & ~w_r_hs & (r_ar_done | w_ar_hs);
    end
  end
endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// tb_axi4_lite_arbiter_2to1: directed vector table for arbitration plus hand sequences for
// split AW/W, stalled R, stray B, write-then-read, contention and mid-transaction reset.
module tb_axi4_lite_arbiter_2to1;
  logic aclk, aresetn;
  logic [31:0] s0_awaddr, s1_awaddr, s0_wdata, s1_wdata, s0_araddr, s1_araddr;
  logic [2:0] s0_awprot, s1_awprot, s0_arprot, s1_arprot;
  logic [3:0] s0_wstrb, s1_wstrb;
  logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [1:0] s0_bresp, s1_bresp, s0_rresp, s1_rresp, m_bresp, m_rresp;
  logic [31:0] s0_rdata, s1_rdata, m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0] m_awprot, m_arprot;
  logic [3:0] m_wstrb;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic grant_valid, grant_id, grant_wr;
  int n_err = 0, n_chk = 0;
  typedef struct packed {logic a0, w0, r0, a1, w1, r1, id, wr;} vec_t;
  vec_t vec[9];
  vec_t v;

  axi4_lite_arbiter_2to1 dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s0_araddr(s0_araddr), .s0_arprot(s0_arprot), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .s1_araddr(s1_araddr), .s1_arprot(s1_arprot), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_valid(grant_valid), .grant_id(grant_id), .grant_wr(grant_wr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_req();
    {s0_awvalid, s0_wvalid, s0_arvalid, s1_awvalid, s1_wvalid, s1_arvalid} = '0;
    {s0_bready, s0_rready, s1_bready, s1_rready} = '0;
    {m_awready, m_wready, m_arready, m_bvalid, m_rvalid} = '0;
  endtask

  initial begin
    // {s0 aw,w,ar, s1 aw,w,ar, expected grant_id, expected grant_wr}; first contention goes to s0
    vec[0] = 8'b110_110_0_1;
    vec[1] = 8'b110_110_1_1;
    vec[2] = 8'b001_001_0_0;
    vec[3] = 8'b001_000_0_0;
    vec[4] = 8'b000_111_1_1;
    vec[5] = 8'b111_001_0_1;
    vec[6] = 8'b001_110_1_1;
    vec[7] = 8'b010_000_0_1;
    vec[8] = 8'b000_001_1_0;
    aresetn = 1'b0;
    clr_req();
    s0_awaddr = 32'h100; s1_awaddr = 32'h200; s0_araddr = 32'h110; s1_araddr = 32'h210;
    s0_awprot = 3'd1; s1_awprot = 3'd2; s0_arprot = 3'd3; s1_arprot = 3'd4;
    s0_wdata = 32'h0A0A0A0A; s1_wdata = 32'h0B0B0B0B; s0_wstrb = 4'h3; s1_wstrb = 4'hC;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    s0_awvalid = 1'b1;
    #2;
    chk1("reset grant_valid", grant_valid, 1'b0);
    chk1("reset m_awvalid", m_awvalid, 1'b0);
    chk1("reset s0_awready", s0_awready, 1'b0);
    chk32("reset m_awaddr", m_awaddr, 32'h0);
    @(negedge aclk);
    s0_awvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);
    chk1("idle after release", grant_valid, 1'b0);

    for (int i = 0; i < 9; i++) begin
      v = vec[i];
      {s0_awvalid, s0_wvalid, s0_arvalid} = {v.a0, v.w0, v.r0};
      {s1_awvalid, s1_wvalid, s1_arvalid} = {v.a1, v.w1, v.r1};
      @(negedge aclk);
      chk1($sformatf("vec%0d grant_valid", i), grant_valid, 1'b1);
      chk1($sformatf("vec%0d grant_id", i), grant_id, v.id);
      chk1($sformatf("vec%0d grant_wr", i), grant_wr, v.wr);
      chk32($sformatf("vec%0d owner addr", i), v.wr ? m_awaddr : m_araddr,
            v.wr ? (v.id ? 32'h200 : 32'h100) : (v.id ? 32'h210 : 32'h110));
      chk32($sformatf("vec%0d idle channel addr", i), v.wr ? m_araddr : m_awaddr, 32'h0);
      if (v.id) {s0_awvalid, s0_wvalid, s0_arvalid} = '0;
      else {s1_awvalid, s1_wvalid, s1_arvalid} = '0;
      {m_awready, m_wready, m_arready} = 3'b111;
      @(negedge aclk);
      clr_req();
      if (v.wr) m_bvalid = 1'b1;
      else m_rvalid = 1'b1;
      {s0_bready, s0_rready, s1_bready, s1_rready} = 4'hF;
      @(negedge aclk);
      chk1($sformatf("vec%0d done", i), grant_valid, 1'b0);
      clr_req();
    end

    // W accepted three cycles ahead of AW
    s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF;
    s0_awvalid = 1'b1; s0_wvalid = 1'b1; m_wready = 1'b1;
    @(negedge aclk);
    chk1("split m_wvalid", m_wvalid, 1'b1);
    chk32("split m_wdata", m_wdata, 32'hDEADBEEF);
    chk32("split m_wstrb", 32'(m_wstrb), 32'hF);
    chk1("split s1_wready", s1_wready, 1'b0);
    @(negedge aclk);
    chk1("split m_wvalid after W", m_wvalid, 1'b0);
    chk1("split s0_wready after W", s0_wready, 1'b0);
    s0_wvalid = 1'b0; m_wready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk1($sformatf("split m_awvalid held %0d", k), m_awvalid, 1'b1);
      @(negedge aclk);
    end
    m_awready = 1'b1;
    #1;
    chk1("split s0_awready", s0_awready, 1'b1);
    @(negedge aclk);
    chk1("split m_awvalid after AW", m_awvalid, 1'b0);
    s0_awvalid = 1'b0; m_awready = 1'b0;
    m_bvalid = 1'b1; s0_bready = 1'b1; s1_bready = 1'b1;
    #1;
    chk1("split s0_bvalid", s0_bvalid, 1'b1);
    chk1("split s1_bvalid", s1_bvalid, 1'b0);
    @(negedge aclk);
    chk1("split done", grant_valid, 1'b0);
    clr_req();

    // Read with the requester stalling R for two cycles
    s0_araddr = 32'h10; s0_arvalid = 1'b1; m_arready = 1'b1;
    @(negedge aclk);
    chk1("rd grant_wr", grant_wr, 1'b0);
    chk32("rd m_araddr", m_araddr, 32'h10);
    @(negedge aclk);
    chk1("rd m_arvalid after AR", m_arvalid, 1'b0);
    s0_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b00; s1_rready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk1($sformatf("rd s0_rvalid %0d", k), s0_rvalid, 1'b1);
      chk1($sformatf("rd s1_rvalid %0d", k), s1_rvalid, 1'b0);
      chk1($sformatf("rd m_rready %0d", k), m_rready, 1'b0);
      chk32($sformatf("rd s0_rdata %0d", k), s0_rdata, 32'h12345678);
      @(negedge aclk);
    end
    chk1("rd still granted", grant_valid, 1'b1);
    s0_rready = 1'b1;
    @(negedge aclk);
    chk1("rd done", grant_valid, 1'b0);
    clr_req();

    // Stray B while idle
    m_bvalid = 1'b1; m_bresp = 2'b10; s0_bready = 1'b1; s1_bready = 1'b1;
    #1;
    chk1("stray m_bready", m_bready, 1'b0);
    chk1("stray s0_bvalid", s0_bvalid, 1'b0);
    chk1("stray s1_bvalid", s1_bvalid, 1'b0);
    chk32("stray s1_bresp", 32'(s1_bresp), 32'h2);
    @(negedge aclk);
    chk1("stray state", grant_valid, 1'b0);
    clr_req();
    m_bresp = 2'b00;

    // s1 write and read together: write first, then read after an idle cycle
    {s1_awvalid, s1_wvalid, s1_arvalid} = 3'b111;
    {m_awready, m_wready, m_arready} = 3'b111;
    @(negedge aclk);
    chk1("wr1 grant_id", grant_id, 1'b1);
    chk1("wr1 grant_wr", grant_wr, 1'b1);
    chk1("wr1 m_arvalid", m_arvalid, 1'b0);
    @(negedge aclk);
    s1_awvalid = 1'b0; s1_wvalid = 1'b0;
    m_bvalid = 1'b1; s1_bready = 1'b1;
    @(negedge aclk);
    chk1("wr1 gap", grant_valid, 1'b0);
    m_bvalid = 1'b0;
    @(negedge aclk);
    chk1("rd1 grant_valid", grant_valid, 1'b1);
    chk1("rd1 grant_id", grant_id, 1'b1);
    chk1("rd1 grant_wr", grant_wr, 1'b0);
    chk1("rd1 m_arvalid", m_arvalid, 1'b1);
    @(negedge aclk);
    s1_arvalid = 1'b0;
    m_rvalid = 1'b1; s1_rready = 1'b1;
    @(negedge aclk);
    chk1("rd1 done", grant_valid, 1'b0);
    clr_req();

    // Continuous write contention from reset release, then reset during an s1 write
    aresetn = 1'b0;
    {s0_awvalid, s0_wvalid, s1_awvalid, s1_wvalid} = 4'hF;
    {s0_bready, s1_bready, m_awready, m_wready} = 4'hF;
    @(negedge aclk);
    chk1("rst m_awvalid", m_awvalid, 1'b0);
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk1($sformatf("rr%0d grant_valid", k), grant_valid, 1'b1);
      chk1($sformatf("rr%0d grant_id", k), grant_id, 1'(k % 2));
      @(negedge aclk);
      m_bvalid = 1'b1;
      @(negedge aclk);
      chk1($sformatf("rr%0d done", k), grant_valid, 1'b0);
      m_bvalid = 1'b0;
    end
    m_wready = 1'b0;
    @(negedge aclk);
    chk1("rr3 grant_id", grant_id, 1'b1);
    @(negedge aclk);
    chk1("rr3 aw done", m_awvalid, 1'b0);
    chk1("rr3 w pending", m_wvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk1("midrst m_wvalid", m_wvalid, 1'b0);
    chk1("midrst grant_valid", grant_valid, 1'b0);
    chk1("midrst s1_awready", s1_awready, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk1("post rst grant_valid", grant_valid, 1'b1);
    chk1("post rst grant_id", grant_id, 1'b0);
    clr_req();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axi4_lite_arbiter_2to1.md
AXI4_LITE_ARBITER_2TO1 -- requirements
Module: axi4_lite_arbiter_2to1

Interface
REQ-001 Parameters: none; address and data fixed at 32 bits, strobe 4 bits, prot 3 bits, resp 2 bits.
REQ-002 aclk  in  1  single clock; all state updates on rising edge.
REQ-003 aresetn  in  1  asynchronous active-low reset.
REQ-004 s0_aw{addr,prot,valid} / s0_awready  in 32,3,1 / out 1  requester 0 write address.
REQ-005 s0_w{data,strb,valid} / s0_wready  in 32,4,1 / out 1  requester 0 write data.
REQ-006 s0_b{resp,valid} / s0_bready  out 2,1 / in 1  requester 0 write response.
REQ-007 s0_ar{addr,prot,valid} / s0_arready  in 32,3,1 / out 1  requester 0 read address.
REQ-008 s0_r{data,resp,valid} / s0_rready  out 32,2,1 / in 1  requester 0 read data.
REQ-009 s1_* ports identical to REQ-004..008 for requester 1.
REQ-010 m_aw*, m_w*, m_ar* out; m_awready, m_wready, m_arready in; m_b*, m_r* in; m_bready, m_rready out: shared slave port, same widths.
REQ-011 grant_valid  out  1  transaction in progress; grant_id  out  1  owning requester; grant_wr  out  1  1=write, 0=read.

Function
REQ-012 FSM states IDLE, WR, RD; one transaction outstanding at a time on the shared port.
REQ-013 Write request of requester i = si_awvalid | si_wvalid; read request = si_arvalid.
REQ-014 IDLE: if any request, register winner and go to WR (winner's write request) or RD; decision takes one cycle, m_* valids assert the cycle after.
REQ-015 Between requesters: round-robin; requester not equal to last_grant wins when both request; lone requester always wins.
REQ-016 Within the winning requester, write has priority over read.
REQ-017 IDLE: all m_*valid, m_bready, m_rready = 0; all si_*ready, si_bvalid, si_rvalid = 0.
REQ-018 WR: m_aw*/m_w* payload from owner; m_awvalid = owner awvalid & ~aw_done; m_wvalid = owner wvalid & ~w_done; owner awready/wready = m_awready/m_wready gated by same done flags.
REQ-019 aw_done/w_done set on respective handshake, cleared on leaving WR; AW and W may complete in either order or same cycle.
REQ-020 WR: owner bvalid = m_bvalid, m_bready = owner bready; on m_bvalid & m_bready go to IDLE and last_grant <= owner.
REQ-021 RD: m_ar* from owner, m_arvalid = owner arvalid & ~ar_done; owner arready = m_arready & ~ar_done; owner rvalid = m_rvalid, m_rready = owner rready; on m_rvalid & m_rready go to IDLE, last_grant <= owner.
REQ-022 Non-owner: all readies and bvalid/rvalid 0; m_bresp, m_rdata, m_rresp broadcast to both requesters unconditionally.
REQ-023 m_aw*/m_w*/m_ar* payload driven 0 when not in the corresponding state.
REQ-024 Stray m_bvalid/m_rvalid outside WR/RD ignored (ready held 0); no state change.
REQ-025 New grant no earlier than the cycle after a response handshake; no back-to-back grant in the completing cycle.
REQ-026 grant_valid = (state != IDLE); grant_id and grant_wr stable for the whole transaction.

Reset
REQ-027 aresetn low: state IDLE, last_grant = 1 (requester 0 wins first contention), done flags 0, all outputs 0, immediately and asynchronously.
REQ-028 Reset mid-transaction abandons it; m_*valid drop without handshake; first grant after release follows REQ-027.

Verification
REQ-029 Both request writes at reset release -> s0 granted first (grant_id=0), s1 granted after s0 B handshake; then s0 and s1 alternate under continuous contention.
REQ-030 s1 asserts awvalid and arvalid together, s0 idle -> write (grant_wr=1) to s1 completes, then read granted to s1.
REQ-031 Slave accepts W 3 cycles before AW, data 0xDEADBEEF strb 0xF -> m_wvalid drops after W handshake, m_awvalid held until AW handshake, one B returned to owner only.
REQ-032 s0 read addr 0x10, slave returns rdata 0x12345678 rresp 0 with rready low 2 cycles -> s0_rvalid held, s1_rvalid 0, IDLE after handshake.
REQ-033 aresetn low during WR after AW handshake -> all m_ valids 0 same cycle, grant_valid 0, next grant to s0.
REQ-034 m_bvalid pulsed while IDLE -> m_bready 0, no s*_bvalid, state unchanged.
